seq_bcd_converter: RTL and testbench

Multi-cycle binary-to-BCD converter for the KPN display path. It pulls one 16-bit unsigned word from the LCD FIFO using a read/empty handshake. It converts the word with an iterative shift-add-3 (double-dabble) datapath, one bit per cycle, and presents a registered 5-digit packed-BCD result to the LCD and seven-segment writers. A one-cycle `wr` strobe marks each new result.

---
 rtl/seq_bcd_converter.sv | 92 +++++++++
 tb/tb_seq_bcd_converter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_bcd_converter.sv
// Multi-cycle binary-to-BCD converter: pulls one word from a FIFO, runs one
// double-dabble iteration per cycle, and publishes a registered packed-BCD result.
module seq_bcd_converter #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  empty,
   input  logic [WIDTH-1:0]      entry_1,
   output logic                  rd,
   output logic [4*DIGITS-1:0]   bcd_number,
   output logic                  wr,
   output logic                  busy,
   output logic [1:0]            state_dbg
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Handshake: rd is a one-cycle strobe raised only in IDLE while empty is low;
   // the FIFO word is valid in the following cycle and captured in READ.
   state_t state, next_state;

   logic [WIDTH-1:0]    bin_reg;
   logic [4*DIGITS-1:0] acc;
   logic [4*DIGITS-1:0] acc_adj;
   logic [CW-1:0]       cnt;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (!empty) next_state = READ;
         READ:    next_state = SHIFT;
         SHIFT:   if (cnt == CW'(1)) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // rd is gated by rst so a held reset never pops a word from the FIFO.
   always_comb begin
      rd        = (state == IDLE) && !empty && !rst;
      busy      = (state != IDLE);
      state_dbg = state;
   end

   // Add-3 per digit; each nibble is adjusted on its own so no carry crosses digits.
   always_comb begin
      acc_adj = acc;
      for (int i = 0; i < DIGITS; i++) begin
         if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bin_reg    <= '0;
         acc        <= '0;
         cnt        <= '0;
         bcd_number <= '0;
         wr         <= 1'b0;
      end else begin
         wr <= (state == DONE);
         case (state)
            READ: begin
               bin_reg <= entry_1;
               acc     <= '0;
               cnt     <= CW'(WIDTH);
            end
            SHIFT: begin
               {acc, bin_reg} <= {acc_adj, bin_reg} << 1;
               cnt            <= cnt - CW'(1);
            end
            DONE:    bcd_number <= acc;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_bcd_converter.sv
// Directed bench for seq_bcd_converter: FIFO model plus rd/wr monitor, with
// one task per scenario comparing against hand-computed BCD values and latencies.
module tb_seq_bcd_converter;

   localparam int WIDTH  = 16;
   localparam int DIGITS = 5;
   localparam int LAT    = WIDTH + 3;
   localparam logic [1:0] SHIFT_ST = 2'd2;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                empty = 1'b1;
   logic [WIDTH-1:0]    entry_1 = '0;
   logic                rd;
   logic [4*DIGITS-1:0] bcd_number;
   logic                wr;
   logic                busy;
   logic [1:0]          state_dbg;

   seq_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .clk        (clk),
      .rst        (rst),
      .empty      (empty),
      .entry_1    (entry_1),
      .rd         (rd),
      .bcd_number (bcd_number),
      .wr         (wr),
      .busy       (busy),
      .state_dbg  (state_dbg)
   );

   always #5 clk = ~clk;

   logic [WIDTH-1:0]    fifo_q[$];
   logic [4*DIGITS-1:0] exp_q[$];
   bit                  hold_empty = 1'b0;
   int                  cyc = 0;
   int                  rd_cyc[$];
   int                  wr_cyc[$];
   logic [4*DIGITS-1:0] wr_val[$];
   int                  rd_bad = 0;
   int                  checks = 0;
   int                  passes = 0;

   // FIFO model and monitor: sample strobes mid-cycle, pop on rd.
   always @(negedge clk) begin
      cyc++;
      if (rd === 1'b1) begin
         rd_cyc.push_back(cyc);
         if (empty) rd_bad++;
         if (fifo_q.size() > 0) entry_1 = fifo_q.pop_front();
      end
      if (wr === 1'b1) begin
         wr_cyc.push_back(cyc);
         wr_val.push_back(bcd_number);
      end
   end

   always @(posedge clk) begin
      #1;
      empty = hold_empty || (fifo_q.size() == 0);
   end

   function automatic logic [4*DIGITS-1:0] wv(input int i);
      if (i < wr_val.size()) return wr_val[i];
      return 'x;
   endfunction

   function automatic int wc(input int i);
      if (i < wr_cyc.size()) return wr_cyc[i];
      return -1000;
   endfunction

   function automatic int rc(input int i);
      if (i < rd_cyc.size()) return rd_cyc[i];
      return -2000;
   endfunction

   task automatic clear_logs();
      rd_cyc.delete();
      wr_cyc.delete();
      wr_val.delete();
      rd_bad = 0;
   endtask

   task automatic wait_wr(input int n, input int budget);
      int i = 0;
      while (wr_cyc.size() < n && i < budget) begin
         @(negedge clk); #1;
         i++;
      end
   endtask

   task automatic test_reset();
      int k;
      clear_logs();
      fifo_q.push_back(16'd0);
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         checks++; if (rd !== 1'b0) $display("FAIL reset_rd: got %b want 0", rd); else passes++;
         checks++; if (wr !== 1'b0) $display("FAIL reset_wr: got %b want 0", wr); else passes++;
         checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
         checks++; if (bcd_number !== 20'h00000) $display("FAIL reset_bcd: got %h want 00000", bcd_number); else passes++;
      end
      @(posedge clk); #2;
      rst = 1'b0;
      k = cyc;
      for (int i = 0; i < 5 && rd_cyc.size() == 0; i++) begin
         @(negedge clk); #1;
      end
      checks++; if (rc(0) !== k + 1) $display("FAIL reset_first_rd: got cycle %0d want %0d", rc(0), k + 1); else passes++;
   endtask

   task automatic test_zero();
      wait_wr(1, LAT + 10);
      repeat (3) @(negedge clk); #1;
      checks++; if (wr_cyc.size() !== 1) $display("FAIL zero_wr_count: got %0d want 1", wr_cyc.size()); else passes++;
      checks++; if (rd_cyc.size() !== 1) $display("FAIL zero_rd_count: got %0d want 1", rd_cyc.size()); else passes++;
      checks++; if (wv(0) !== 20'h00000) $display("FAIL zero_value: got %h want 00000", wv(0)); else passes++;
      checks++; if (wc(0) - rc(0) !== LAT) $display("FAIL zero_latency: got %0d want %0d", wc(0) - rc(0), LAT); else passes++;
   endtask

   task automatic test_single(input logic [WIDTH-1:0] w, input logic [4*DIGITS-1:0] exp);
      int bad_nib = 0;
      clear_logs();
      fifo_q.push_back(w);
      wait_wr(1, LAT + 10);
      repeat (3) @(negedge clk); #1;
      for (int d = 0; d < DIGITS; d++) if (!(wv(0)[4*d +: 4] <= 4'd9)) bad_nib++;
      checks++; if (wr_cyc.size() !== 1) $display("FAIL single_wr_count(%0d): got %0d want 1", w, wr_cyc.size()); else passes++;
      checks++; if (wv(0) !== exp) $display("FAIL single_value(%0d): got %h want %h", w, wv(0), exp); else passes++;
      checks++; if (wc(0) - rc(0) !== LAT) $display("FAIL single_latency(%0d): got %0d want %0d", w, wc(0) - rc(0), LAT); else passes++;
      checks++; if (bad_nib !== 0) $display("FAIL single_digit_range(%0d): got %0d bad digits want 0", w, bad_nib); else passes++;
      checks++; if (bcd_number !== exp) $display("FAIL single_hold(%0d): got %h want %h", w, bcd_number, exp); else passes++;
   endtask

   task automatic test_back_to_back();
      hold_empty = 1'b1;
      fifo_q.push_back(16'd1);
      fifo_q.push_back(16'd10);
      fifo_q.push_back(16'd100);
      fifo_q.push_back(16'd59999);
      exp_q.delete();
      exp_q.push_back(20'h00001);
      exp_q.push_back(20'h00010);
      exp_q.push_back(20'h00100);
      exp_q.push_back(20'h59999);
      repeat (2) @(posedge clk);
      #2;
      clear_logs();
      hold_empty = 1'b0;
      wait_wr(4, 4 * LAT + 20);
      repeat (3) @(negedge clk); #1;
      checks++; if (wr_cyc.size() !== 4) $display("FAIL b2b_wr_count: got %0d want 4", wr_cyc.size()); else passes++;
      checks++; if (rd_cyc.size() !== 4) $display("FAIL b2b_rd_count: got %0d want 4", rd_cyc.size()); else passes++;
      checks++; if (rd_bad !== 0) $display("FAIL b2b_rd_while_empty: got %0d want 0", rd_bad); else passes++;
      for (int i = 0; i < 4; i++) begin
         checks++; if (wv(i) !== exp_q[i]) $display("FAIL b2b_value[%0d]: got %h want %h", i, wv(i), exp_q[i]); else passes++;
         if (i > 0) begin
            checks++; if (wc(i) - wc(i-1) !== LAT) $display("FAIL b2b_spacing[%0d]: got %0d want %0d", i, wc(i) - wc(i-1), LAT); else passes++;
         end
         if (i < 3) begin
            checks++; if (rc(i+1) !== wc(i)) $display("FAIL b2b_rd_with_wr[%0d]: got rd cycle %0d want %0d", i, rc(i+1), wc(i)); else passes++;
         end
      end
   endtask

   task automatic test_hold_idle();
      int changed = 0;
      int busy_hi = 0;
      clear_logs();
      repeat (50) begin
         @(negedge clk); #1;
         if (bcd_number !== 20'h59999) changed++;
         if (busy !== 1'b0) busy_hi++;
      end
      checks++; if (changed !== 0) $display("FAIL hold_bcd_stable: got %0d changes want 0", changed); else passes++;
      checks++; if (busy_hi !== 0) $display("FAIL hold_busy: got %0d busy cycles want 0", busy_hi); else passes++;
      checks++; if (rd_cyc.size() !== 0) $display("FAIL hold_rd: got %0d want 0", rd_cyc.size()); else passes++;
      checks++; if (wr_cyc.size() !== 0) $display("FAIL hold_wr: got %0d want 0", wr_cyc.size()); else passes++;
   endtask

   task automatic test_reset_mid();
      clear_logs();
      fifo_q.push_back(16'd4321);
      for (int i = 0; i < 10 && rd_cyc.size() == 0; i++) begin
         @(negedge clk); #1;
      end
      repeat (9) @(posedge clk);
      #2;
      checks++; if (state_dbg !== SHIFT_ST) $display("FAIL mid_in_shift: got state %0d want %0d", state_dbg, SHIFT_ST); else passes++;
      rst = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0;
      checks++; if (busy !== 1'b0) $display("FAIL mid_busy_after_rst: got %b want 0", busy); else passes++;
      checks++; if (bcd_number !== 20'h00000) $display("FAIL mid_bcd_after_rst: got %h want 00000", bcd_number); else passes++;
      repeat (30) @(negedge clk); #1;
      checks++; if (wr_cyc.size() !== 0) $display("FAIL mid_no_wr: got %0d want 0", wr_cyc.size()); else passes++;
      checks++; if (rd_cyc.size() !== 1) $display("FAIL mid_no_reread: got %0d want 1", rd_cyc.size()); else passes++;
      checks++; if (bcd_number !== 20'h00000) $display("FAIL mid_bcd_hold: got %h want 00000", bcd_number); else passes++;
      clear_logs();
      fifo_q.push_back(16'd77);
      wait_wr(1, LAT + 10);
      checks++; if (wv(0) !== 20'h00077) $display("FAIL mid_next_value: got %h want 00077", wv(0)); else passes++;
      checks++; if (wc(0) - rc(0) !== LAT) $display("FAIL mid_next_latency: got %0d want %0d", wc(0) - rc(0), LAT); else passes++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_zero();
      test_single(16'd65535, 20'h65535);
      test_single(16'd12345, 20'h12345);
      test_single(16'd9999,  20'h09999);
      test_back_to_back();
      test_hold_idle();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
